piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, 8, parallel word width in bits; SHALL be >= 2.
REQ-002 Port: clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: shift_en  in  1  bit-advance strobe; presented bit is consumed on a rising edge with shift_en=1.
REQ-005 Port: load_data  in  WIDTH  parallel word to serialize.
REQ-006 Port: load_valid  in  1  load_data valid.
REQ-007 Port: load_ready  out  1  block can accept a word this cycle.
REQ-008 Port: dout  out  1  serial bit, MSB first; drives the downstream sequence detector's din.
REQ-009 Port: dout_valid  out  1  dout carries a frame bit.
REQ-010 Port: frame_done  out  1  one-cycle pulse after the final bit of a frame is consumed.
REQ-011 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-012 States SHALL be IDLE, SHIFT and PAR (PAR exists only when SER_PARITY_EN is defined).
REQ-013 A transfer SHALL occur on a rising edge with load_valid=1 and load_ready=1.
REQ-014 load_ready SHALL be 1 in IDLE, and 1 while the final bit of the frame is presented and shift_en=1; otherwise 0.
REQ-015 On a transfer: capture load_data into the shift register, bit counter=0, state=SHIFT, dout=load_data[WIDTH-1], dout_valid=1, all registered at that edge (latency 1 cycle).
REQ-016 In SHIFT, each edge with shift_en=1 SHALL advance dout to the next lower bit and increment the counter.
REQ-017 With shift_en=0, state, counter, dout and dout_valid SHALL hold unchanged.
REQ-018 Final bit = data bit 0 without parity; parity bit with parity.
REQ-019 When the final bit is consumed with a simultaneous transfer, the next word's MSB SHALL appear on the following cycle with no dout_valid gap.
REQ-020 When the final bit is consumed without a transfer, state=IDLE, dout=0, dout_valid=0.
REQ-021 frame_done SHALL be registered, high for exactly one cycle following the edge that consumes the final bit, including the back-to-back case.
REQ-022 load_valid in SHIFT or PAR while load_ready=0 SHALL be ignored; load_data SHALL not be sampled.
REQ-023 load_data changes after the transfer edge SHALL NOT affect the frame in progress.

Reset
REQ-024 rst=0 SHALL immediately force state=IDLE, counter=0, shift register=0, dout=0, dout_valid=0, frame_done=0, busy=0.
REQ-025 load_ready SHALL read 1 during reset; no transfer SHALL occur while rst=0.
REQ-026 Reset mid-frame SHALL discard the frame with no frame_done pulse; the first transfer after release SHALL start a fresh frame.

Configuration
REQ-027 Macro SER_PARITY_EN SHALL enable an even-parity bit: after data bit 0, state PAR presents XOR of all WIDTH data bits, giving a WIDTH+1-bit frame.
REQ-028 Without SER_PARITY_EN, the frame SHALL be exactly WIDTH bits, PAR SHALL be absent, and SHIFT returns directly to IDLE/SHIFT.

Verification
REQ-029 WIDTH=8, shift_en=1, load 8'hA5 -> dout 1,0,1,0,0,1,0,1 on 8 consecutive cycles, dout_valid high 8 cycles, one frame_done pulse; with SER_PARITY_EN a 9th bit 0.
REQ-030 load_valid held high with 8'hA0 then 8'h0A -> 16 (18 with parity) contiguous dout_valid cycles, no gap, two frame_done pulses.
REQ-031 shift_en toggling 1,0,1,0..., load 8'hFF -> each bit held 2 cycles, 16 cycles total without parity; parity bit 0 with parity.
REQ-032 rst=0 asserted after 3 bits of 8'h5A -> dout=0, dout_valid=0, busy=0 immediately, no frame_done; after release, load 8'h07 -> 0,0,0,0,0,1,1,1, parity 1.
REQ-033 load_valid=0 for 20 cycles in IDLE -> load_ready=1, dout_valid=0, busy=0, frame_done=0 throughout.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, MSB first, with back-to-back frame support.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
//
// state | meaning
// IDLE  | no frame in progress, ready to accept a word
// SHIFT | presenting data bits WIDTH-1 down to 0
// PAR   | presenting the even-parity bit (SER_PARITY_EN only)
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t             state, state_n;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               fd_n;
    logic               last_bit;
    logic               xfer;
`ifdef SER_PARITY_EN
    logic               par_q, par_n;
`endif

`ifdef SER_PARITY_EN
    assign last_bit = (state == PAR);
    assign dout     = (state == PAR) ? par_q : shreg[WIDTH-1];
`else
    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);
    assign dout     = shreg[WIDTH-1];
`endif

    assign load_ready = (state == IDLE) || (last_bit && shift_en);
    assign xfer       = load_valid && load_ready;
    assign busy       = (state != IDLE);
    assign dout_valid = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
`ifdef SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            frame_done <= fd_n;
`ifdef SER_PARITY_EN
            par_q      <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        fd_n    = 1'b0;
`ifdef SER_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            IDLE: ;
            SHIFT: begin
                if (shift_en) begin
                    if (cnt == CNT_LAST) begin
`ifdef SER_PARITY_EN
                        state_n = PAR;
                        shreg_n = '0;
`else
                        state_n = IDLE;
                        shreg_n = '0;
                        fd_n    = 1'b1;
`endif
                    end else begin
                        shreg_n = shreg << 1;
                        cnt_n   = cnt + 1'b1;
                    end
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                if (shift_en) begin
                    state_n = IDLE;
                    fd_n    = 1'b1;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                shreg_n = '0;
            end
        endcase

        // A transfer can only coincide with IDLE or the final-bit consume, so it overrides.
        if (xfer) begin
            state_n = SHIFT;
            shreg_n = load_data;
            cnt_n   = '0;
`ifdef SER_PARITY_EN
            par_n   = ^load_data;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=8).
// Honors SER_PARITY_EN to extend expected frames by the parity bit.
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             shift_en;
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             dout;
    logic             dout_valid;
    logic             frame_done;
    logic             busy;

    int total = 0;
    int bad   = 0;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (shift_en),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit i of the serialized frame for word d: data MSB first, then parity.
    function automatic logic frame_bit(input logic [WIDTH-1:0] d, input int i);
        if (i < WIDTH) return d[WIDTH-1-i];
        return ^d;
    endfunction

    task automatic expect_frame_end(input string tag);
        check({tag, "_fd"}, 32'(frame_done), 32'd1);
        check({tag, "_dv_end"}, 32'(dout_valid), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_dout_end"}, 32'(dout), 32'd0);
        tick();
        check({tag, "_fd_one"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        int fd_count;

        rst        = 1'b0;
        shift_en   = 1'b1;
        load_data  = 8'hC3;
        load_valid = 1'b1;
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dv", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd1);
        tick();
        check("rst_no_xfer", 32'(busy), 32'd0);
        load_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Single frame 8'hA5 with continuous shift_en.
        w = 8'hA5;
        load_data  = w;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        load_data  = 8'h00;
        for (int i = 0; i < FL; i++) begin
            check($sformatf("a5_bit%0d", i), 32'(dout), 32'(frame_bit(w, i)));
            check($sformatf("a5_dv%0d", i), 32'(dout_valid), 32'd1);
            check($sformatf("a5_fd%0d", i), 32'(frame_done), 32'd0);
            check($sformatf("a5_rdy%0d", i), 32'(load_ready), (i == FL - 1) ? 32'd1 : 32'd0);
            tick();
        end
        expect_frame_end("a5");

        // Back-to-back 8'hA0 then 8'h0A with load_valid held high.
        load_data  = 8'hA0;
        load_valid = 1'b1;
        tick();
        load_data  = 8'h0A;
        fd_count   = 0;
        for (int c = 0; c < 2 * FL; c++) begin
            w = (c < FL) ? 8'hA0 : 8'h0A;
            check($sformatf("b2b_bit%0d", c), 32'(dout), 32'(frame_bit(w, c % FL)));
            check($sformatf("b2b_dv%0d", c), 32'(dout_valid), 32'd1);
            check($sformatf("b2b_fd%0d", c), 32'(frame_done), (c == FL) ? 32'd1 : 32'd0);
            if (frame_done) fd_count++;
            if (c == FL) load_valid = 1'b0;
            tick();
        end
        if (frame_done) fd_count++;
        check("b2b_fd_count", 32'(fd_count), 32'd2);
        expect_frame_end("b2b");

        // shift_en toggling: each bit of 8'hFF held two cycles.
        w = 8'hFF;
        load_data  = w;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < 2 * FL; c++) begin
            shift_en = (c % 2 == 1);
            #1;
            check($sformatf("tog_bit%0d", c), 32'(dout), 32'(frame_bit(w, c / 2)));
            check($sformatf("tog_dv%0d", c), 32'(dout_valid), 32'd1);
            tick();
        end
        shift_en = 1'b1;
        expect_frame_end("tog");

        // Reset after three bits of 8'h5A, then a fresh 8'h07 frame.
        w = 8'h5A;
        load_data  = w;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mid_bit%0d", i), 32'(dout), 32'(frame_bit(w, i)));
            tick();
        end
        check("mid_pre_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_dv", 32'(dout_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fd", 32'(frame_done), 32'd0);
        check("mid_rst_ready", 32'(load_ready), 32'd1);
        load_data  = 8'hFF;
        load_valid = 1'b1;
        tick();
        check("mid_rst_no_xfer", 32'(busy), 32'd0);
        check("mid_rst_fd2", 32'(frame_done), 32'd0);
        w = 8'h07;
        load_data = w;
        rst = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            check($sformatf("post_bit%0d", i), 32'(dout), 32'(frame_bit(w, i)));
            check($sformatf("post_dv%0d", i), 32'(dout_valid), 32'd1);
            check($sformatf("post_fd%0d", i), 32'(frame_done), 32'd0);
            tick();
        end
        expect_frame_end("post");

        // Idle with no load requests.
        load_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check($sformatf("idle_rdy%0d", c), 32'(load_ready), 32'd1);
            check($sformatf("idle_dv%0d", c), 32'(dout_valid), 32'd0);
            check($sformatf("idle_busy%0d", c), 32'(busy), 32'd0);
            check($sformatf("idle_fd%0d", c), 32'(frame_done), 32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
